decode: RTL and testbench

- RV32I instruction decode stage.
- Takes a 32-bit instruction word and produces the register addresses rs1/rs2/rd, a sign-extended immediate and a 4-bit ALU operation code.
- All outputs are registered: one pipeline stage between fetch and register read/execute.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_imm.sv | 20 ++
 rtl/decode.sv | 67 ++++++
 tb/tb_decode.sv | 82 ++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes, funct3 names, ALU op codes and instruction formats shared by the decode stage.
package decode_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10
  } aluop_e;
  typedef enum logic [2:0] {FMT_X, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
  // alt is funct7[5]; only register-register ops may turn ADD into SUB
  function automatic aluop_e alu_arith(input logic [2:0] f3, input logic alt, input logic is_op);
    case (f3)
      F3_ADD:  return (alt && is_op) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_imm.sv
// decode_imm: combinational sign-extended immediate generator for the selected instruction format.
module decode_imm
  import decode_pkg::*;
(
  input  logic [31:0]     ins,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'b0};
      FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
  end
endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage; classifies the opcode, muxes register fields and immediate,
// selects the ALU op and registers everything for one cycle of latency.
module decode
  import decode_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     ins,
  output logic [4:0]      oprs1,
  output logic [4:0]      oprs2,
  output logic [4:0]      oprd,
  output logic [3:0]      aluop,
  output logic [XLEN-1:0] imm
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       alt;
  fmt_e       fmt;
  aluop_e     aluop_d, aluop_q;
  logic [4:0] oprs1_d, oprs1_q, oprs2_d, oprs2_q, oprd_d, oprd_q;
  logic [XLEN-1:0] imm_d, imm_q;
  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign alt    = ins[30];
  always_comb begin
    fmt     = FMT_X;
    aluop_d = ALU_ADD;
    case (opcode)
      OPC_OP:     begin fmt = FMT_R; aluop_d = alu_arith(f3, alt, 1'b1); end
      OPC_OP_IMM: begin fmt = FMT_I; aluop_d = alu_arith(f3, alt, 1'b0); end
      OPC_LOAD:   fmt = FMT_I;
      OPC_JALR:   fmt = FMT_I;
      OPC_STORE:  fmt = FMT_S;
      OPC_BRANCH: begin fmt = FMT_B; aluop_d = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB; end
      OPC_JAL:    fmt = FMT_J;
      OPC_LUI:    begin fmt = FMT_U; aluop_d = ALU_PASSB; end
      OPC_AUIPC:  fmt = FMT_U;
      default:    fmt = FMT_X;
    endcase
  end
  always_comb begin
    oprs1_d = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? ins[19:15] : 5'd0;
    oprs2_d = (fmt inside {FMT_R, FMT_S, FMT_B}) ? ins[24:20] : 5'd0;
    oprd_d  = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? ins[11:7] : 5'd0;
  end
  decode_imm u_imm (.ins(ins), .fmt(fmt), .imm(imm_d));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oprs1_q <= '0;
      oprs2_q <= '0;
      oprd_q  <= '0;
      imm_q   <= '0;
      aluop_q <= ALU_ADD;
    end else begin
      oprs1_q <= oprs1_d;
      oprs2_q <= oprs2_d;
      oprd_q  <= oprd_d;
      imm_q   <= imm_d;
      aluop_q <= aluop_d;
    end
  end
  assign oprs1 = oprs1_q;
  assign oprs2 = oprs2_q;
  assign oprd  = oprd_q;
  assign imm   = imm_q;
  assign aluop = aluop_q;
endmodule

// File: tb/tb_decode.sv
// tb_decode: directed-vector bench for the RV32I decode stage with hand-computed expectations.
module tb_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins;
  logic [4:0]  oprs1, oprs2, oprd;
  logic [3:0]  aluop;
  logic [31:0] imm;
  int tests = 0;
  int fails = 0;
  decode dut (
    .clk(clk), .rst_n(rst_n), .ins(ins),
    .oprs1(oprs1), .oprs2(oprs2), .oprd(oprd), .aluop(aluop), .imm(imm)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] im, input logic [3:0] op);
    check({tag, ".oprd"},  {27'd0, oprd},  {27'd0, rd});
    check({tag, ".oprs1"}, {27'd0, oprs1}, {27'd0, rs1});
    check({tag, ".oprs2"}, {27'd0, oprs2}, {27'd0, rs2});
    check({tag, ".imm"},   imm, im);
    check({tag, ".aluop"}, {28'd0, aluop}, {28'd0, op});
  endtask
  task automatic step(input logic [31:0] i);
    ins = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    ins   = 32'h40628233;
    #1;
    check_all("reset_now", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    check_all("reset_held", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    rst_n = 1'b1;
    check_all("release_no_edge", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    step(32'hff700293);
    check_all("addi_neg", 5'd5, 5'd0, 5'd0, 32'hFFFFFFF7, 4'd0);
    step(32'h00700313);
    check_all("addi_pos", 5'd6, 5'd0, 5'd0, 32'h00000007, 4'd0);
    step(32'h40628233);
    check_all("sub", 5'd4, 5'd5, 5'd6, 32'h0, 4'd1);
    step(32'hFE62AE23);
    check_all("sw", 5'd0, 5'd5, 5'd6, 32'hFFFFFFFC, 4'd0);
    step(32'hFE628CE3);
    check_all("beq", 5'd0, 5'd5, 5'd6, 32'hFFFFFFF8, 4'd1);
    step(32'h0020E263);
    check_all("bltu", 5'd0, 5'd1, 5'd2, 32'h00000004, 4'd4);
    step(32'h123453B7);
    check_all("lui", 5'd7, 5'd0, 5'd0, 32'h12345000, 4'd10);
    step(32'hFFFFF197);
    check_all("auipc", 5'd3, 5'd0, 5'd0, 32'hFFFFF000, 4'd0);
    step(32'h001000EF);
    check_all("jal", 5'd1, 5'd0, 5'd0, 32'h00000800, 4'd0);
    step(32'h4034D413);
    check_all("srai", 5'd8, 5'd9, 5'd0, 32'h00000403, 4'd7);
    step(32'h40010093);
    check_all("addi_bit30", 5'd1, 5'd2, 5'd0, 32'h00000400, 4'd0);
    step(32'h0000007F);
    check_all("illegal", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    step(32'h40628233);
    rst_n = 1'b0;
    #1;
    check_all("reset_mid_async", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_all("reset_mid_release", 5'd0, 5'd0, 5'd0, 32'h0, 4'd0);
    step(32'h40628233);
    check_all("after_reset", 5'd4, 5'd5, 5'd6, 32'h0, 4'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
